// File: rtl/idu_uop_queue.sv
// idu_uop_queue: DEPTH-entry FIFO of decoded micro-ops between IDU and EXU.
// Valid/ready on both sides, synchronous flush, occupancy count.
// Optional macro YSYX_UOPQ_BYPASS_EN: an empty queue forwards in_uop to out_uop
// combinationally, and a uop consumed that way is never written.
//
// Packed uop, MSB to LSB:
//   pc[XLEN] inst[32] op1[XLEN] op2[XLEN] opj[XLEN] imm[XLEN] rd[REG_LEN]
//   alu_op[5] func3[3] ren wen jen ben system func3_z csr_wen ebreak ecall mret
// That is five XLEN-wide fields, so the packed width is 5*XLEN+32+REG_LEN+18.
module idu_uop_queue #(
    parameter  int XLEN    = 32,
    parameter  int REG_LEN = 5,
    parameter  int DEPTH   = 4,
    localparam int UOP_W   = 5*XLEN + 32 + REG_LEN + 18,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [UOP_W-1:0] in_uop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [UOP_W-1:0] out_uop,
    output logic [CNT_W-1:0] count
);

    logic [UOP_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             bypass;
    logic             store;

    // Handshake decode; full/empty come only from the count register.
    always_comb begin
        full      = (count == CNT_W'(DEPTH));
        empty     = (count == '0);
        in_ready  = reset && !full;
        bypass    = 1'b0;
`ifdef YSYX_UOPQ_BYPASS_EN
        bypass    = reset && !flush && empty && in_valid;
        out_uop   = empty ? in_uop : mem[head];
`else
        out_uop   = mem[head];
`endif
        out_valid = !empty || bypass;
        push      = in_valid && in_ready;
        pop       = !empty && out_ready;
        // A bypassed uop consumed in the same cycle never occupies an entry.
        store     = push && !(bypass && out_ready);
    end

    // Pointer and occupancy state: reset beats flush beats push/pop.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (store) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({store, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are intentionally left untouched by reset.
    always_ff @(posedge clock) begin
        if (reset && !flush && store) begin
            mem[tail] <= in_uop;
        end
    end

endmodule
